// File: rtl/bus_ram_ctrl_if.sv
// rtl/bus_ram_ctrl_if.sv - CPU bus address/control and RAM status signals
interface bus_ram_ctrl_if #(
    parameter int BUS_ADDR_W = 8
);
    logic [BUS_ADDR_W-1:0] bus_addr;
    logic                  bus_we;
    logic                  clr_req;
    logic                  clr_busy;
    logic                  wp_viol;
    logic                  ram_oe;

    modport master (
        output bus_addr,
        output bus_we,
        output clr_req,
        input  clr_busy,
        input  wp_viol,
        input  ram_oe
    );

    modport slave (
        input  bus_addr,
        input  bus_we,
        input  clr_req,
        output clr_busy,
        output wp_viol,
        output ram_oe
    );
endinterface

// File: rtl/bus_ram_ctrl.sv
// rtl/bus_ram_ctrl.sv - parametrised bus data RAM with write-protect window and zero-fill sequencer
module bus_ram_ctrl #(
    parameter int    BUS_ADDR_W   = 8,
    parameter int    ADDR_W       = 7,
    parameter int    BASE_ADDR    = 0,
    parameter string INIT_FILE    = "ram.txt",
    parameter bit    CLEAR_ON_RST = 1'b0,
    parameter bit    WP_EN        = 1'b0,
    parameter int    WP_LO        = 0,
    parameter int    WP_HI        = 0
) (
    input  logic          clk,
    input  logic          rst_n,
    inout  wire  [7:0]    bus_data,
    bus_ram_ctrl_if.slave bus
);
    localparam int DEPTH = 1 << ADDR_W;
    localparam logic [BUS_ADDR_W-1:0] LOCAL_MASK = BUS_ADDR_W'(DEPTH - 1);
    localparam logic [BUS_ADDR_W-1:0] BASE       = BUS_ADDR_W'(BASE_ADDR);
    localparam logic [ADDR_W-1:0]     WP_LO_A    = ADDR_W'(WP_LO);
    localparam logic [ADDR_W-1:0]     WP_SPAN    = ADDR_W'(WP_HI - WP_LO);
    localparam logic [ADDR_W-1:0]     LAST_A     = ADDR_W'(DEPTH - 1);

    typedef enum logic {
        S_IDLE,
        S_CLEAR
    } state_t;

    state_t            state;
    logic [ADDR_W-1:0] ptr;
    logic [7:0]        rd_reg;
    logic              rd_drv;
    logic              wp_viol_q;
    logic              clr_busy_q;

    logic [7:0]        mem [DEPTH];

    logic              sel;
    logic [ADDR_W-1:0] la;
    logic [ADDR_W-1:0] la_off;
    logic              prot;
    logic              bus_wr;
    logic              bus_rd;
    logic              clearing;

    assign sel      = ((bus.bus_addr & ~LOCAL_MASK) == BASE);
    assign la       = bus.bus_addr[ADDR_W-1:0];
    // Offset from window start; a single unsigned compare covers both bounds.
    assign la_off   = la - WP_LO_A;
    assign prot     = WP_EN && (la_off <= WP_SPAN);
    assign clearing = rst_n && (state == S_CLEAR);
    assign bus_wr   = rst_n && (state == S_IDLE) && sel && bus.bus_we && !prot;
    assign bus_rd   = (state == S_IDLE) && sel && !bus.bus_we;

    always_ff @(posedge clk) begin
        if (clearing) begin
            mem[ptr] <= 8'h00;
        end else if (bus_wr) begin
            mem[la] <= bus_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= CLEAR_ON_RST ? S_CLEAR : S_IDLE;
            clr_busy_q <= CLEAR_ON_RST;
            ptr        <= '0;
            rd_reg     <= 8'h00;
            rd_drv     <= 1'b0;
            wp_viol_q  <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    rd_drv    <= bus_rd;
                    wp_viol_q <= sel && bus.bus_we && prot;
                    if (bus_rd) begin
                        rd_reg <= mem[la];
                    end
                    if (bus.clr_req) begin
                        state      <= S_CLEAR;
                        clr_busy_q <= 1'b1;
                    end
                end
                S_CLEAR: begin
                    rd_drv    <= 1'b0;
                    wp_viol_q <= 1'b0;
                    if (ptr == LAST_A) begin
                        state      <= S_IDLE;
                        clr_busy_q <= 1'b0;
                        ptr        <= '0;
                    end else begin
                        ptr <= ptr + 1'b1;
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    // Released while not sourcing so the CPU can drive write data.
    assign bus_data     = rd_drv ? rd_reg : 8'hzz;
    assign bus.ram_oe   = rd_drv;
    assign bus.wp_viol  = wp_viol_q;
    assign bus.clr_busy = clr_busy_q;
endmodule

// File: tb/tb_bus_ram_ctrl.sv
// tb/tb_bus_ram_ctrl.sv - scoreboard bench for bus_ram_ctrl with a behavioural memory model
module tb_bus_ram_ctrl;
    localparam int BASE  = 8'h80;
    localparam int DEPTH = 128;
    localparam int WLO   = 8'h10;
    localparam int WHI   = 8'h1F;

    logic       clk;
    logic       rst_n;
    logic [7:0] tb_data;
    logic       tb_drv;
    wire  [7:0] bus_data;

    bus_ram_ctrl_if #(.BUS_ADDR_W(8)) ifc ();

    assign bus_data = tb_drv ? tb_data : 8'hzz;

    bus_ram_ctrl #(
        .BUS_ADDR_W  (8),
        .ADDR_W      (7),
        .BASE_ADDR   (BASE),
        .INIT_FILE   (""),
        .CLEAR_ON_RST(1'b1),
        .WP_EN       (1'b1),
        .WP_LO       (WLO),
        .WP_HI       (WHI)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .bus_data(bus_data),
        .bus     (ifc)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        bit       oe;
        bit [7:0] data;
        bit       viol;
        bit       busy;
        int       tag;
    } exp_t;

    exp_t     sb[$];
    bit [7:0] mmem[DEPTH];
    int       clear_left;
    bit       last_oe;
    int       total;
    int       bad;

    task automatic chk(input string name, input int tag, input int got, input int exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s tag=%0d got=%0h exp=%0h", name, tag, got, exp);
        end
    endtask

    // Called at a negedge: applies one bus cycle, predicts the state after the next posedge.
    task automatic drive(input bit [7:0] addr, input bit we, input bit [7:0] d, input bit clr, input int tag);
        exp_t e;
        bit   sel;
        int   la;
        ifc.bus_addr = addr;
        ifc.bus_we   = we;
        ifc.clr_req  = clr;
        tb_data      = d;
        tb_drv       = we;
        e      = '{oe: 1'b0, data: 8'h00, viol: 1'b0, busy: 1'b0, tag: tag};
        sel    = (int'(addr) >= BASE) && (int'(addr) < BASE + DEPTH);
        la     = int'(addr) - BASE;
        if (clear_left > 0) begin
            mmem[DEPTH - clear_left] = 8'h00;
            clear_left--;
        end else begin
            if (sel && we) begin
                if (la >= WLO && la <= WHI) e.viol = 1'b1;
                else mmem[la] = d;
            end
            if (sel && !we) begin
                e.oe   = 1'b1;
                e.data = mmem[la];
            end
            if (clr) clear_left = DEPTH;
        end
        e.busy = (clear_left > 0);
        sb.push_back(e);
        last_oe = e.oe;
        @(negedge clk);
    endtask

    task automatic access(input bit [7:0] addr, input bit we, input bit [7:0] d, input bit clr, input int tag);
        if (we && last_oe) drive(8'h00, 1'b0, 8'h00, 1'b0, tag);
        drive(addr, we, d, clr, tag);
    endtask

    task automatic idle(input int n, input int tag);
        for (int i = 0; i < n; i++) drive(8'h00, 1'b0, 8'h00, 1'b0, tag);
    endtask

    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                chk("ram_oe", e.tag, int'(ifc.ram_oe), int'(e.oe));
                chk("wp_viol", e.tag, int'(ifc.wp_viol), int'(e.viol));
                chk("clr_busy", e.tag, int'(ifc.clr_busy), int'(e.busy));
                if (e.oe) chk("rdata", e.tag, int'(bus_data), int'(e.data));
            end
        end
    end

    initial begin
        total        = 0;
        bad          = 0;
        last_oe      = 1'b0;
        clear_left   = 0;
        tb_drv       = 1'b0;
        tb_data      = 8'h00;
        ifc.bus_addr = 8'h00;
        ifc.bus_we   = 1'b0;
        ifc.clr_req  = 1'b0;
        rst_n        = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_oe", 0, int'(ifc.ram_oe), 0);
        chk("rst_viol", 0, int'(ifc.wp_viol), 0);
        chk("rst_busy", 0, int'(ifc.clr_busy), 1);
        rst_n      = 1'b1;
        clear_left = DEPTH;
        idle(DEPTH, 1);

        access(8'h85, 1'b1, 8'hA5, 1'b0, 2);
        access(8'h00, 1'b0, 8'h00, 1'b0, 2);
        access(8'h85, 1'b0, 8'h00, 1'b0, 2);
        access(8'h40, 1'b0, 8'h00, 1'b0, 3);
        access(8'h05, 1'b0, 8'h00, 1'b0, 3);
        idle(1, 3);

        access(8'h92, 1'b1, 8'h3C, 1'b0, 4);
        access(8'h92, 1'b0, 8'h00, 1'b0, 4);
        access(8'h8F, 1'b1, 8'h11, 1'b0, 5);
        access(8'h90, 1'b1, 8'h22, 1'b0, 5);
        access(8'h9F, 1'b1, 8'h33, 1'b0, 5);
        access(8'hA0, 1'b1, 8'h44, 1'b0, 5);
        access(8'h8F, 1'b0, 8'h00, 1'b0, 6);
        access(8'h90, 1'b0, 8'h00, 1'b0, 6);
        access(8'h9F, 1'b0, 8'h00, 1'b0, 6);
        access(8'hA0, 1'b0, 8'h00, 1'b0, 6);
        access(8'hFF, 1'b1, 8'h5A, 1'b0, 7);
        access(8'hFF, 1'b0, 8'h00, 1'b0, 7);
        access(8'h80, 1'b0, 8'h00, 1'b0, 7);

        for (int i = 0; i < DEPTH; i++) access(8'(BASE + i), 1'b1, 8'hFF, 1'b0, 8);
        access(8'h85, 1'b0, 8'h00, 1'b1, 9);
        access(8'h82, 1'b1, 8'h77, 1'b1, 9);
        idle(DEPTH, 9);
        for (int i = 0; i < DEPTH; i++) access(8'(BASE + i), 1'b0, 8'h00, 1'b0, 10);

        for (int i = 0; i < 600; i++)
            access(8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)), 8'($urandom),
                   ($urandom_range(0, 63) == 0), 11);
        idle(DEPTH + 2, 11);

        for (int i = 0; i < 16; i++) access(8'(BASE + 40 + i), 1'b1, 8'(i + 1), 1'b0, 12);
        access(8'h00, 1'b0, 8'h00, 1'b1, 12);
        idle(40, 12);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_oe", 13, int'(ifc.ram_oe), 0);
        chk("mid_rst_busy", 13, int'(ifc.clr_busy), 1);
        @(negedge clk);
        rst_n      = 1'b1;
        clear_left = DEPTH;
        last_oe    = 1'b0;
        idle(DEPTH, 14);
        for (int i = 0; i < DEPTH; i++) access(8'(BASE + i), 1'b0, 8'h00, 1'b0, 15);
        idle(1, 15);

        repeat (3) @(posedge clk);
        #2;
        chk("drain", 16, sb.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
